// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module : popcount_pkg
// Purpose: Shared FSM state encoding, default geometry and width helper for
//          the range popcount engine.
// Rev    : 1.0  initial release
// ============================================================================
package popcount_pkg;

   // Scan FSM states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 32;

   // Bits needed to hold any count from 0 up to width*depth inclusive
   function automatic int tot_width(input int width, input int depth);
      return $clog2(width * depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sp.sv
`default_nettype none
// ============================================================================
// Module : ram_sp
// Purpose: Single-port synchronous RAM, one write port, registered read data
//          (one cycle read latency). Contents are not reset.
// Ports  : clk      - clock
//          i_we     - write strobe
//          i_addr   - shared read/write address
//          i_wdata  - write data
//          o_rdata  - registered read data (value at i_addr before any write)
// Rev    : 1.0  initial release
// ============================================================================
module ram_sp
   import popcount_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/popcount_scan.sv
`default_nettype none
// ============================================================================
// Module : popcount_scan
// Purpose: Scans an inclusive, wrap-around address range of an internal RAM
//          and accumulates the number of ones (or zeros) over all scanned
//          words using a shift-right datapath with per-word early exit.
// Ports  : clk       - clock, rising edge
//          reset_n   - asynchronous active-low reset
//          s         - start/continue level, held high until done
//          mode      - 0 count ones, 1 count zeros (sampled at start)
//          addr_lo   - first address (sampled at start)
//          addr_hi   - last address, inclusive (sampled at start)
//          wr_en     - RAM write strobe, honoured only in IDLE
//          wr_addr   - RAM write address
//          wr_data   - RAM write data
//          busy      - high while scanning (FETCH/LOAD/SHIFT)
//          done      - high in DONE only
//          total     - running / final count
// Rev    : 1.0  initial release
// ============================================================================
module popcount_scan
   import popcount_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int TOT_W  = tot_width(WIDTH, DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s,
   input  logic              mode,
   input  logic [ADDR_W-1:0] addr_lo,
   input  logic [ADDR_W-1:0] addr_hi,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic [TOT_W-1:0]  total
);

   state_t            r_state;
   logic              r_mode;
   logic              r_busy;
   logic              r_done;
   logic [ADDR_W-1:0] r_cur;
   logic [ADDR_W-1:0] r_hi;
   logic [WIDTH-1:0]  r_sh;
   logic [TOT_W-1:0]  r_total;

   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [WIDTH-1:0]  w_dout;

   // The host owns the RAM port while idle; the scanner owns it otherwise,
   // which is also what makes writes outside IDLE fall on the floor.
   assign w_ram_we   = (r_state == IDLE) && wr_en;
   assign w_ram_addr = (r_state == IDLE) ? wr_addr : r_cur;

   ram_sp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (wr_data),
      .o_rdata (w_dout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_mode  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cur   <= '0;
         r_hi    <= '0;
         r_sh    <= '0;
         r_total <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s) begin
                  r_mode  <= mode;
                  r_hi    <= addr_hi;
                  r_cur   <= addr_lo;
                  r_total <= '0;
                  r_state <= FETCH;
                  r_busy  <= 1'b1;
               end
            end
            FETCH: begin
               if (!s) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               if (!s) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  // Counting zeros is counting ones of the inverted word
                  r_sh    <= r_mode ? ~w_dout : w_dout;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!s) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (r_sh != '0) begin
                  r_total <= r_total + TOT_W'(r_sh[0]);
                  r_sh    <= r_sh >> 1;
               end else if (r_cur == r_hi) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  // Wraps through DEPTH-1 -> 0 at ADDR_W bits
                  r_cur   <= r_cur + ADDR_W'(1);
                  r_state <= FETCH;
               end
            end
            DONE: begin
               if (!s) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_popcount_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_popcount_scan
// Purpose: Scoreboard bench for popcount_scan (WIDTH=8, DEPTH=32, mem[i]=i).
//          Each scan pushes its hand-computed total and latency; a monitor
//          pops and compares on every rising edge of done.
// Rev    : 1.0  initial release
// ============================================================================
module tb_popcount_scan;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int TOT_W  = 9;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              s = 1'b0;
   logic              mode = 1'b0;
   logic [ADDR_W-1:0] addr_lo = '0;
   logic [ADDR_W-1:0] addr_hi = '0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [WIDTH-1:0]  wr_data = '0;
   logic              busy;
   logic              done;
   logic [TOT_W-1:0]  total;

   popcount_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .s       (s),
      .mode    (mode),
      .addr_lo (addr_lo),
      .addr_hi (addr_hi),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .total   (total)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int tot;
      int lat;
      int start;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic prev_done = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: compares on every done rising edge
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy && done) begin
            checks++;
            errors++;
            $display("FAIL busy_done_overlap: busy=1 done=1 at t=%0t", $time);
         end
         if (done && !prev_done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: total=%0d, no scan pending", total);
            end else begin
               e = sb.pop_front();
               check("sb_total", int'(total), e.tot);
               check("sb_latency", cyc - e.start, e.lat);
            end
         end
         prev_done = done;
      end
   endtask

   // One complete scan; optionally attempts a RAM write while busy
   task automatic run_scan(input int lo, input int hi, input logic m,
                           input int exp_tot, input int exp_lat, input bit poke);
      exp_t e;
      bit   seen;
      @(negedge clk);
      addr_lo = ADDR_W'(lo);
      addr_hi = ADDR_W'(hi);
      mode    = m;
      s       = 1'b1;
      e.tot   = exp_tot;
      e.lat   = exp_lat;
      e.start = cyc + 1;
      sb.push_back(e);
      seen = 0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         @(negedge clk);
         if (poke && k == 3) begin
            wr_en   = 1'b1;
            wr_addr = 5'd7;
            wr_data = 8'hFF;
         end else begin
            wr_en = 1'b0;
         end
         if (done) seen = 1;
      end
      wr_en = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL scan_timeout: lo=%0d hi=%0d done=%0d, expected 1", lo, hi, done);
         void'(sb.pop_front());
      end
      repeat (2) @(negedge clk);
      check("done_hold", int'(done), 1);
      check("total_hold", int'(total), exp_tot);
      s = 1'b0;
      @(negedge clk);
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), 0);
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset state
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_total", int'(total), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Preload mem[i] = i
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = WIDTH'(i);
      end
      @(negedge clk);
      wr_en = 1'b0;

      //        lo  hi  mode tot  lat  poke
      run_scan( 0,  0, 1'b0,   0,   3, 0);
      run_scan( 3,  3, 1'b0,   2,   5, 0);
      run_scan( 3,  3, 1'b1,   6,  11, 0);
      run_scan( 0, 31, 1'b0,  80, 225, 0);
      run_scan( 0, 31, 1'b1, 176, 352, 0);
      run_scan( 5,  4, 1'b0,  80, 225, 0);
      run_scan(30,  1, 1'b0,  10,  23, 1);
      run_scan( 7,  7, 1'b0,   3,   6, 0);

      // Abort during SHIFT of word 5 after its first shift
      @(negedge clk);
      addr_lo = 5'd5;
      addr_hi = 5'd6;
      mode    = 1'b0;
      s       = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_busy_pre", int'(busy), 1);
      s = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_total", int'(total), 1);
      repeat (5) @(negedge clk);
      check("abort_done_late", int'(done), 0);

      // Asynchronous reset mid-scan
      @(negedge clk);
      addr_lo = 5'd0;
      addr_hi = 5'd31;
      s       = 1'b1;
      repeat (20) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_total", int'(total), 0);
      @(negedge clk);
      s = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // RAM contents survive reset
      run_scan( 3,  3, 1'b1,   6,  11, 0);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
